// File: rtl/weight_mem_loader_pkg.sv
// Shared definitions for the weight/bias loaders: FSM encoding and config-bus width.
// Imported by the loader top, its ID comparator and the loader interface.
package weight_mem_loader_pkg;

    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/weight_mem_loader_if.sv
// Config-bus word stream in, BRAM write port and status out, as seen by one loader.
// The slave side is the loader; the master side is whoever sources the weights.
interface weight_mem_loader_if
    import weight_mem_loader_pkg::*;
#(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic                    weightValid;
    logic [CFG_W-1:0]        weightValue;
    logic [CFG_W-1:0]        config_layer_num;
    logic [CFG_W-1:0]        config_neuron_num;
    logic                    clear;
    logic                    wen;
    logic [addressWidth:0]   waddr;
    logic [dataWidth-1:0]    win;
    logic                    load_done;
    logic                    overflow;

    modport master (
        output weightValid, weightValue, config_layer_num, config_neuron_num, clear,
        input  wen, waddr, win, load_done, overflow
    );

    modport slave (
        input  weightValid, weightValue, config_layer_num, config_neuron_num, clear,
        output wen, waddr, win, load_done, overflow
    );

endinterface

// File: rtl/weight_mem_loader_id_match.sv
// Combinational layer/neuron filter: hit when a valid word targets this neuron.
// Zero latency, no state; shared with the bias loader.
module weight_id_match
    import weight_mem_loader_pkg::*;
#(
    parameter int layerNo  = 1,
    parameter int neuronNo = 36
) (
    input  logic             valid_i,
    input  logic [CFG_W-1:0] layer_i,
    input  logic [CFG_W-1:0] neuron_i,
    output logic             hit_o
);

    assign hit_o = valid_i
                && (layer_i  == CFG_W'(layerNo))
                && (neuron_i == CFG_W'(neuronNo));

endmodule

// File: rtl/weight_mem_loader.sv
// Filters config-bus weight words by ID and writes them to one neuron's BRAM at auto-incrementing addresses.
// Write issued one cycle after the hit; no backpressure, sustains one write per cycle.
module weight_mem_loader
    import weight_mem_loader_pkg::*;
#(
    parameter int layerNo      = 1,
    parameter int neuronNo     = 36,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input logic               clk,
    input logic               rst_n,
    weight_mem_loader_if.slave bus
);

    localparam int CNT_W = addressWidth + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numWeight - 1);

    logic hit;

    load_state_t          state_q, state_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic                 wen_q, wen_d;
    logic [CNT_W-1:0]     waddr_q, waddr_d;
    logic [dataWidth-1:0] win_q, win_d;
    logic                 ovf_q, ovf_d;

    weight_id_match #(
        .layerNo  (layerNo),
        .neuronNo (neuronNo)
    ) u_id_match (
        .valid_i  (bus.weightValid),
        .layer_i  (bus.config_layer_num),
        .neuron_i (bus.config_neuron_num),
        .hit_o    (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            win_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        win_d   = win_q;
        ovf_d   = ovf_q;

        // clear outranks a coincident hit, so that word is dropped
        if (bus.clear) begin
            state_d = IDLE;
            wcnt_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        wen_d   = 1'b1;
                        waddr_d = '0;
                        win_d   = bus.weightValue[dataWidth-1:0];
                        if (numWeight == 1) begin
                            state_d = DONE;
                            wcnt_d  = '0;
                        end else begin
                            state_d = LOAD;
                            wcnt_d  = CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (hit) begin
                        wen_d   = 1'b1;
                        waddr_d = wcnt_q;
                        win_d   = bus.weightValue[dataWidth-1:0];
                        if (wcnt_q == LAST_IDX) begin
                            state_d = DONE;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d  = wcnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (hit) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.win       = win_q;
    assign bus.load_done = (state_q == DONE);
    assign bus.overflow  = ovf_q;

endmodule

// File: doc/weight_mem_loader.md
Name: weight_mem_loader

Overview:
- Write-side companion to the per-neuron weight BRAM. The neuron's MAC path reads that BRAM through ren/raddr/wout.
- Accepts a stream of weight words from the configuration bus and filters them by layer/neuron ID.
- Drives registered wen/waddr/win into one neuron's weight memory with an auto-incrementing address.
- Counts the weights written, flags completion and rejects surplus words.

Parameters:
- layerNo, 1, layer ID this loader answers to.
- neuronNo, 36, neuron ID this loader answers to.
- numWeight, 784, number of weights per neuron. Must be ≤ 2**addressWidth.
- addressWidth, 10, BRAM address width. waddr is addressWidth+1 bits to match raddr.
- dataWidth, 16, weight word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- weightValid  in  1  one-cycle strobe: weightValue holds a weight word
- weightValue  in  32  weight word; bits [dataWidth-1:0] are used, upper bits are ignored
- config_layer_num  in  32  target layer ID of the current word
- config_neuron_num  in  32  target neuron ID of the current word
- clear  in  1  synchronous restart: address back to 0, flags cleared
- wen  out  1  BRAM write enable
- waddr  out  addressWidth+1  BRAM write address
- win  out  dataWidth  BRAM write data
- load_done  out  1  level: all numWeight words written
- overflow  out  1  sticky: a matching word arrived while in DONE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: wen=0, waddr=0, win=0, load_done=0, overflow=0.
  - Internal: state=IDLE, wcnt=0.
- hit = weightValid && config_layer_num==layerNo && config_neuron_num==neuronNo (full 32-bit compares).
- Latency: the write is issued one cycle after the hit.
  - wen=1 for exactly one cycle.
  - waddr = wcnt value at hit time.
  - win = weightValue[dataWidth-1:0].
- No backpressure. The source may present a hit every cycle and the loader sustains one write per cycle.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: wcnt=0. On hit: issue write 0, wcnt←1, go to LOAD. With numWeight==1, go straight to DONE.
  - LOAD: on hit, issue write at wcnt.
    - If wcnt==numWeight-1: wcnt←0, go to DONE, load_done←1 in the same edge as that final wen.
    - Otherwise wcnt←wcnt+1.
    - Non-hit cycles hold state.
  - DONE: load_done=1. A hit is not written (wen stays 0) and sets overflow←1. Remain in DONE until clear.
- clear: in any state, next edge gives state=IDLE, wcnt=0, load_done=0, overflow=0. wen is 0 that cycle.
- clear and hit in the same cycle: clear wins and the word is dropped (no wen).
- Non-matching words: fully ignored, with no state, counter or flag change.
- Address never exceeds numWeight-1. wcnt width is addressWidth+1 and must not wrap.
- Reset during LOAD: partial contents stay in the BRAM. Loading restarts at address 0, and rewriting overwrites the old words.
- wen is registered, never combinational from the inputs.

Decomposition:
- Shared package/include:
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - Config-word width constant (32).
- One natural sub-module: weight_id_match, the combinational layer/neuron comparator producing hit. It is reused by the bias loader.
- Counter, FSM and output registers stay in the top module.

Test Plan:
1. Reset then 784 consecutive hits (layer 1, neuron 36, value = index):
   - wen pulses 784 times.
   - waddr runs 0..783 and win==waddr.
   - load_done rises on the edge of the write to 783.
   - overflow=0.
2. Words addressed to neuron 35, then layer 2/neuron 36 → no wen, wcnt stays 0, load_done=0.
3. Hits with gaps (valid every 3rd cycle, 10 words) → waddr 0..9 with no gaps or duplicates, and state stays LOAD.
4. After DONE, one extra hit value 0xABCD → no wen, overflow=1 and sticky. Then clear → load_done=0, overflow=0, and the next hit writes address 0.
5. clear asserted in the same cycle as a hit at wcnt=5 → no write; the next hit writes address 0.
6. rst_n pulsed low mid-cycle during LOAD (wcnt=100) → all outputs 0 immediately without waiting for a clock edge, and the next hit writes address 0.
